// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: state encoding, state type,
// default geometry and a small state-decoding helper.
package timer_pkg;

    // Default counter/period width and prescale ratio.
    localparam int DEFAULT_N        = 8;
    localparam int DEFAULT_PRESCALE = 4;

    // State encoding. The value 2'b11 is never entered and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    typedef enum logic [1:0] {
        TIMER_IDLE = 2'b00,
        TIMER_RUN  = 2'b01,
        TIMER_HOLD = 2'b10
    } timer_state_e;

    // A timer is busy while it is counting or frozen mid-count.
    function automatic logic state_busy(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/timer_count_core.sv
// Down-counting datapath for the interval timer. Priority of controls is
// clear > load > decrement. The zero flag reflects the registered value.
module timer_count_core
    import timer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dec,
    output logic [N-1:0] count,
    output logic         zero
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    // Next counter value from the clear/load/decrement controls.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - N'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer controller: configuration handshake, IDLE/RUN/HOLD
// sequencing, expire pulse and sticky interrupt around timer_count_core.
// Optional feature macro: TIMER_CTRL_PRESCALE_EN -- when defined, ticks come
// from a divide-by-PRESCALE prescaler; otherwise every cycle is a tick.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [N-1:0] cfg_period,
    input  logic         cfg_periodic,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         irq_ack,
    output logic         busy,
    output logic         expire,
    output logic         irq,
    output logic [N-1:0] count
);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] period_q, period_d;
    logic         mode_q, mode_d;
    logic         expire_q, expire_d;
    logic         irq_q, irq_d;

    logic         core_clr;
    logic         core_load;
    logic         core_dec;
    logic         core_zero;
    logic         tick;

`ifdef TIMER_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;

    assign tick = (presc_q == PW'(PRESCALE - 1));

    // Prescaler: runs only in RUN, freezes in HOLD, sits at zero otherwise
    // so that every start begins a full prescale interval.
    always_comb begin
        presc_d = '0;
        if (!stop) begin
            if (state_q == ST_RUN) begin
                if (pause) begin
                    presc_d = presc_q;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                end
            end else if (state_q == ST_HOLD) begin
                presc_d = presc_q;
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // FSM, configuration latch, datapath controls, expire and irq.
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        mode_d    = mode_q;
        expire_d  = 1'b0;
        core_clr  = 1'b0;
        core_load = 1'b0;
        core_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Handshake is independent of commands; a start in the same
                // cycle still loads the previously latched period.
                if (cfg_valid) begin
                    period_d = cfg_period;
                    mode_d   = cfg_periodic;
                end
                if (stop) begin
                    core_clr = 1'b1;
                end else if (!pause && start) begin
                    state_d   = ST_RUN;
                    core_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    core_clr = 1'b1;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    if (core_zero) begin
                        expire_d = 1'b1;
                        if (mode_q) begin
                            core_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        core_dec = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    core_clr = 1'b1;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                core_clr = 1'b1;
            end
        endcase

        // A new expiry wins over a coincident acknowledge.
        irq_d = expire_d ? 1'b1 : (irq_q & ~irq_ack);
    end

    // Control and configuration registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
            irq_q    <= irq_d;
        end
    end

    timer_count_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clr      (core_clr),
        .load     (core_load),
        .load_val (period_q),
        .dec      (core_dec),
        .count    (count),
        .zero     (core_zero)
    );

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = state_busy(state_q);
    assign expire    = expire_q;
    assign irq       = irq_q;

endmodule
